// File: rtl/periph_rr_arbiter_pkg.sv
// Shared types and constants for the peripheral round-robin arbiter.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK      = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // Circular successor of a requester index within n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/periph_rr_arbiter_rr_prio_sel.sv
// Circular priority selector: first asserted request at or after ptr wins.
module rr_prio_sel #(
    parameter int NB_MASTERS = 2
) (
    input  logic [NB_MASTERS-1:0]                                 req,
    input  logic [((NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1)-1:0] ptr,
    output logic [NB_MASTERS-1:0]                                 sel_onehot,
    output logic [((NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1)-1:0] sel_idx,
    output logic                                                  sel_valid
);

    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    int unsigned      cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic             hit_s;

    // Walk once around the ring from ptr; the first hit locks the result.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
        cand_s     = 32'd0;
        cand_idx_s = '0;
        hit_s      = 1'b0;
        for (int off = 0; off < NB_MASTERS; off++) begin
            cand_s     = 32'(ptr) + 32'(off);
            cand_s     = (cand_s >= 32'(NB_MASTERS)) ? (cand_s - 32'(NB_MASTERS)) : cand_s;
            cand_idx_s = IDX_W'(cand_s);
            hit_s      = ~sel_valid & req[cand_idx_s];
            sel_onehot[cand_idx_s] = sel_onehot[cand_idx_s] | hit_s;
            sel_idx    = hit_s ? cand_idx_s : sel_idx;
            sel_valid  = sel_valid | hit_s;
        end
    end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter funnelling NB_MASTERS TCDM requesters onto one peripheral
// port, one outstanding transaction at a time, with a response watchdog.
module periph_rr_arbiter #(
    parameter int NB_MASTERS     = 2,
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_MASTERS-1:0]                         slv_req_i,
    input  logic [NB_MASTERS-1:0][PER_ADDR_WIDTH-1:0]     slv_add_i,
    input  logic [NB_MASTERS-1:0]                         slv_we_i,
    input  logic [NB_MASTERS-1:0][PER_DATA_WIDTH-1:0]     slv_wdata_i,
    input  logic [NB_MASTERS-1:0][PER_DATA_WIDTH/8-1:0]   slv_be_i,
    output logic [NB_MASTERS-1:0]                         slv_gnt_o,
    output logic [NB_MASTERS-1:0]                         slv_r_valid_o,
    output logic                                          slv_r_opc_o,
    output logic [PER_DATA_WIDTH-1:0]                     slv_r_rdata_o,
    output logic                                          mst_req_o,
    output logic [PER_ADDR_WIDTH-1:0]                     mst_add_o,
    output logic                                          mst_we_o,
    output logic [PER_DATA_WIDTH-1:0]                     mst_wdata_o,
    output logic [PER_DATA_WIDTH/8-1:0]                   mst_be_o,
    input  logic                                          mst_gnt_i,
    input  logic                                          mst_r_valid_i,
    input  logic                                          mst_r_opc_i,
    input  logic [PER_DATA_WIDTH-1:0]                     mst_r_rdata_i,
    output logic                                          busy_o,
    output logic                                          timeout_o
);

    import periph_arb_pkg::*;

    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e              state_r;
    logic [IDX_W-1:0]        owner_r;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [WD_W-1:0]         wd_r;

    logic [NB_MASTERS-1:0]   win_onehot_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_valid_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic                    fwd_s;
    logic                    resp_s;
    logic                    fire_s;
    logic [WD_W-1:0]         wd_inc_s;

    rr_prio_sel #(
        .NB_MASTERS (NB_MASTERS)
    ) u_prio_sel (
        .req        (slv_req_i),
        .ptr        (rr_ptr_r),
        .sel_onehot (win_onehot_s),
        .sel_idx    (win_idx_s),
        .sel_valid  (win_valid_s)
    );

    // A real response always beats a watchdog expiry in the same cycle.
    assign resp_s   = (state_r == ST_WAIT_RESP) & mst_r_valid_i;
    assign wd_inc_s = wd_r + WD_W'(1'b1);
    assign fire_s   = (state_r == ST_WAIT_RESP) & ~mst_r_valid_i
                    & (wd_inc_s == WD_W'(TIMEOUT_CYCLES));

    assign busy_o    = (state_r != ST_IDLE);
    assign timeout_o = fire_s;

    // Pick which requester is forwarded and route the peripheral grant back.
    always_comb begin
        sel_idx_s = owner_r;
        fwd_s     = 1'b0;
        slv_gnt_o = '0;
        case (state_r)
            ST_IDLE: begin
                sel_idx_s = win_idx_s;
                fwd_s     = win_valid_s;
                slv_gnt_o = win_onehot_s & {NB_MASTERS{mst_gnt_i}};
            end
            ST_LOCK: begin
                sel_idx_s = owner_r;
                fwd_s     = slv_req_i[owner_r];
                slv_gnt_o[owner_r] = slv_req_i[owner_r] & mst_gnt_i;
            end
            ST_WAIT_RESP: begin
                sel_idx_s = owner_r;
                fwd_s     = 1'b0;
            end
            default: begin
                sel_idx_s = owner_r;
                fwd_s     = 1'b0;
            end
        endcase
    end

    // Forwarded request fields; held at zero when nothing is being offered.
    always_comb begin
        mst_req_o = fwd_s;
        if (fwd_s) begin
            mst_add_o   = slv_add_i[sel_idx_s];
            mst_we_o    = slv_we_i[sel_idx_s];
            mst_wdata_o = slv_wdata_i[sel_idx_s];
            mst_be_o    = slv_be_i[sel_idx_s];
        end else begin
            mst_add_o   = '0;
            mst_we_o    = 1'b0;
            mst_wdata_o = '0;
            mst_be_o    = '0;
        end
    end

    // Response steering to the owner, with the error word on watchdog expiry.
    always_comb begin
        slv_r_valid_o = '0;
        slv_r_valid_o[owner_r] = resp_s | fire_s;
        if (resp_s) begin
            slv_r_opc_o   = mst_r_opc_i;
            slv_r_rdata_o = mst_r_rdata_i;
        end else if (fire_s) begin
            slv_r_opc_o   = 1'b1;
            slv_r_rdata_o = PER_DATA_WIDTH'(ERR_RDATA);
        end else begin
            slv_r_opc_o   = 1'b0;
            slv_r_rdata_o = '0;
        end
    end

    // Transaction FSM: arbitration pointer, owner latch and watchdog.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            wd_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        owner_r <= win_idx_s;
                        if (mst_gnt_i) begin
                            rr_ptr_r <= IDX_W'(rr_next(32'(win_idx_s), 32'(NB_MASTERS)));
                            wd_r     <= '0;
                            state_r  <= ST_WAIT_RESP;
                        end else begin
                            state_r  <= ST_LOCK;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (!slv_req_i[owner_r]) begin
                        state_r <= ST_IDLE;
                    end else if (mst_gnt_i) begin
                        rr_ptr_r <= IDX_W'(rr_next(32'(owner_r), 32'(NB_MASTERS)));
                        wd_r     <= '0;
                        state_r  <= ST_WAIT_RESP;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_s || fire_s) begin
                        wd_r    <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        wd_r    <= wd_inc_s;
                    end
                end
                default: begin
                    wd_r    <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Self-checking bench for periph_rr_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_periph_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           slv_req, slv_we, slv_gnt, slv_r_valid;
    logic [N-1:0][AW-1:0]   slv_add;
    logic [N-1:0][DW-1:0]   slv_wdata;
    logic [N-1:0][BW-1:0]   slv_be;
    logic                   slv_r_opc;
    logic [DW-1:0]          slv_r_rdata;
    logic                   mst_req, mst_we, mst_gnt, mst_r_valid, mst_r_opc;
    logic [AW-1:0]          mst_add;
    logic [DW-1:0]          mst_wdata, mst_r_rdata;
    logic [BW-1:0]          mst_be;
    logic                   busy, timeout;

    int checks = 0;
    int failures = 0;

    // Reference model: who holds the port, whether the peripheral accepted it,
    // how long we have waited, and who has priority next.
    int       m_owner, m_age, m_prio;
    bit       m_granted;
    logic     e_req, e_opc, e_to, e_busy;
    int       e_sel;
    logic [N-1:0]  e_gnt, e_rv;
    logic [DW-1:0] e_rdata;

    always #5 clk = ~clk;

    periph_rr_arbiter #(
        .NB_MASTERS(N), .PER_ADDR_WIDTH(AW), .PER_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_we_i(slv_we),
        .slv_wdata_i(slv_wdata), .slv_be_i(slv_be),
        .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_r_valid),
        .slv_r_opc_o(slv_r_opc), .slv_r_rdata_o(slv_r_rdata),
        .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_we_o(mst_we),
        .mst_wdata_o(mst_wdata), .mst_be_o(mst_be),
        .mst_gnt_i(mst_gnt), .mst_r_valid_i(mst_r_valid),
        .mst_r_opc_i(mst_r_opc), .mst_r_rdata_i(mst_r_rdata),
        .busy_o(busy), .timeout_o(timeout)
    );

    task automatic drive_quiet();
        slv_req = '0;
        for (int i = 0; i < N; i++) begin
            slv_add[i]   = 32'h0000_1000 + 32'(i);
            slv_wdata[i] = 32'hD000_0000 + 32'(i);
            slv_be[i]    = 4'hF;
            slv_we[i]    = 1'b0;
        end
        mst_gnt = 1'b0; mst_r_valid = 1'b0; mst_r_opc = 1'b0; mst_r_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_quiet();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_quiet();
        slv_req = 3'b001; mst_r_valid = 1'b1; mst_r_opc = 1'b1; mst_r_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        checks++; if (slv_r_valid !== 3'b000) begin failures++; $display("FAIL rst_rvalid got=%b exp=000", slv_r_valid); end
        checks++; if (slv_r_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", slv_r_rdata); end
        checks++; if (slv_gnt !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b exp=000", slv_gnt); end
        @(negedge clk);
        drive_quiet();
        rst_n = 1'b1;
    endtask

    task automatic test_alternate();
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp_oh = ((k % 2) == 0) ? 3'b001 : 3'b010;
            exp_d  = 32'hC0DE_0000 + 32'(k);
            @(negedge clk); slv_req = 3'b011; mst_gnt = 1'b1; mst_r_valid = 1'b0; #1;
            checks++; if (slv_gnt !== exp_oh) begin failures++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, slv_gnt, exp_oh); end
            checks++; if (mst_add !== 32'h0000_1000 + 32'(k % 2)) begin failures++; $display("FAIL alt_add k=%0d got=%h", k, mst_add); end
            @(negedge clk); #1;
            checks++; if ({busy, mst_req, slv_gnt, slv_r_valid} !== 8'b1000_0000) begin failures++; $display("FAIL alt_wait k=%0d got=%b exp=10000000", k, {busy, mst_req, slv_gnt, slv_r_valid}); end
            @(negedge clk); mst_r_valid = 1'b1; mst_r_opc = 1'b0; mst_r_rdata = exp_d; #1;
            checks++; if (slv_r_valid !== exp_oh) begin failures++; $display("FAIL alt_rvalid k=%0d got=%b exp=%b", k, slv_r_valid, exp_oh); end
            checks++; if (slv_r_rdata !== exp_d) begin failures++; $display("FAIL alt_rdata k=%0d got=%h exp=%h", k, slv_r_rdata, exp_d); end
        end
    endtask

    task automatic test_lock();
        apply_reset();
        @(negedge clk); slv_req = 3'b010; mst_gnt = 1'b0; #1;
        checks++; if (mst_add !== 32'h0000_1001 || slv_gnt !== 3'b000) begin failures++; $display("FAIL lock_c0 add=%h gnt=%b exp add=1001 gnt=000", mst_add, slv_gnt); end
        for (int c = 1; c < 3; c++) begin
            @(negedge clk); slv_req = 3'b011; mst_gnt = 1'b0; #1;
            checks++; if (mst_add !== 32'h0000_1001 || slv_gnt !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL lock_hold c=%0d add=%h gnt=%b busy=%b", c, mst_add, slv_gnt, busy); end
        end
        @(negedge clk); mst_gnt = 1'b1; #1;
        checks++; if (slv_gnt !== 3'b010) begin failures++; $display("FAIL lock_gnt got=%b exp=010", slv_gnt); end
        @(negedge clk); mst_r_valid = 1'b1; #1;
        checks++; if (slv_r_valid !== 3'b010) begin failures++; $display("FAIL lock_rvalid got=%b exp=010", slv_r_valid); end
        @(negedge clk); mst_r_valid = 1'b0; #1;
        checks++; if (slv_gnt !== 3'b001) begin failures++; $display("FAIL lock_next got=%b exp=001", slv_gnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        @(negedge clk); slv_req = 3'b100; mst_gnt = 1'b1; #1;
        checks++; if (slv_gnt !== 3'b100) begin failures++; $display("FAIL to_gnt got=%b exp=100", slv_gnt); end
        for (int c = 1; c < TO; c++) begin
            @(negedge clk); slv_req = '0; mst_gnt = 1'b0; #1;
            checks++; if ({timeout, slv_r_valid, busy} !== 5'b0_000_1) begin failures++; $display("FAIL to_wait c=%0d got=%b exp=00001", c, {timeout, slv_r_valid, busy}); end
        end
        @(negedge clk); #1;
        checks++; if ({timeout, slv_r_valid, slv_r_opc} !== 5'b1_100_1) begin failures++; $display("FAIL to_fire got=%b exp=11001", {timeout, slv_r_valid, slv_r_opc}); end
        checks++; if (slv_r_rdata !== 32'hBADACCE5) begin failures++; $display("FAIL to_rdata got=%h exp=badacce5", slv_r_rdata); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); mst_r_valid = 1'b1; mst_r_rdata = 32'h5555_5555; #1;
            checks++; if ({slv_r_valid, timeout, busy} !== 5'b0) begin failures++; $display("FAIL to_late c=%0d got=%b exp=00000", c, {slv_r_valid, timeout, busy}); end
            checks++; if (slv_r_rdata !== 32'h0) begin failures++; $display("FAIL to_late_rdata got=%h exp=0", slv_r_rdata); end
        end
    endtask

    task automatic test_drop();
        apply_reset();
        @(negedge clk); slv_req = 3'b001; mst_gnt = 1'b1; #1;
        checks++; if (slv_gnt !== 3'b001) begin failures++; $display("FAIL drop_g0 got=%b exp=001", slv_gnt); end
        @(negedge clk); mst_r_valid = 1'b1; #1;
        @(negedge clk); slv_req = 3'b101; mst_gnt = 1'b0; mst_r_valid = 1'b0; #1;
        checks++; if (mst_add !== 32'h0000_1002) begin failures++; $display("FAIL drop_win got=%h exp=00001002", mst_add); end
        @(negedge clk); slv_req = 3'b001; mst_gnt = 1'b1; #1;
        checks++; if ({mst_req, slv_gnt, busy} !== 5'b0_000_1) begin failures++; $display("FAIL drop_lock got=%b exp=00001", {mst_req, slv_gnt, busy}); end
        @(negedge clk); slv_req = 3'b101; mst_gnt = 1'b0; #1;
        checks++; if (busy !== 1'b0 || mst_add !== 32'h0000_1002) begin failures++; $display("FAIL drop_ptr busy=%b add=%h exp busy=0 add=00001002", busy, mst_add); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk); slv_req = 3'b010; mst_gnt = 1'b1; #1;
        checks++; if (slv_gnt !== 3'b010) begin failures++; $display("FAIL rmid_gnt got=%b exp=010", slv_gnt); end
        @(negedge clk); rst_n = 1'b0; slv_req = '0; mst_gnt = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b exp=0", busy); end
        @(negedge clk); rst_n = 1'b1; mst_r_valid = 1'b1; mst_r_rdata = 32'h7777_7777; #1;
        @(negedge clk); slv_req = 3'b110; #1;
        checks++; if ({slv_r_valid, busy} !== 4'b0) begin failures++; $display("FAIL rmid_resp got=%b exp=0000", {slv_r_valid, busy}); end
        checks++; if (mst_add !== 32'h0000_1001) begin failures++; $display("FAIL rmid_ptr got=%h exp=00001001", mst_add); end
    endtask

    task automatic test_collision();
        apply_reset();
        @(negedge clk); slv_req = 3'b001; mst_gnt = 1'b1; #1;
        for (int c = 1; c < TO; c++) begin
            @(negedge clk); slv_req = '0; mst_gnt = 1'b0; #1;
        end
        @(negedge clk); mst_r_valid = 1'b1; mst_r_opc = 1'b0; mst_r_rdata = 32'h1234_5678; #1;
        checks++; if ({slv_r_valid, slv_r_opc, timeout} !== 5'b001_0_0) begin failures++; $display("FAIL coll_ctl got=%b exp=00100", {slv_r_valid, slv_r_opc, timeout}); end
        checks++; if (slv_r_rdata !== 32'h1234_5678) begin failures++; $display("FAIL coll_rdata got=%h exp=12345678", slv_r_rdata); end
        @(negedge clk); mst_r_valid = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL coll_idle got=%b exp=0", busy); end
    endtask

    task automatic model_eval();
        e_gnt = '0; e_rv = '0; e_opc = 1'b0; e_rdata = '0; e_to = 1'b0; e_req = 1'b0; e_sel = 0;
        e_busy = (m_owner >= 0);
        if (!m_granted) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!e_req && slv_req[(m_prio + k) % N]) begin
                        e_req = 1'b1; e_sel = (m_prio + k) % N;
                    end
                end
            end else begin
                e_sel = m_owner; e_req = slv_req[m_owner];
            end
            if (e_req && mst_gnt) e_gnt[e_sel] = 1'b1;
        end else if (mst_r_valid) begin
            e_rv[m_owner] = 1'b1; e_opc = mst_r_opc; e_rdata = mst_r_rdata;
        end else if (m_age + 1 == TO) begin
            e_rv[m_owner] = 1'b1; e_opc = 1'b1; e_rdata = 32'hBADACCE5; e_to = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (!m_granted) begin
            if (m_owner >= 0 && !slv_req[m_owner]) begin
                m_owner = -1;
            end else if (e_req) begin
                m_owner = e_sel;
                if (mst_gnt) begin
                    m_granted = 1'b1; m_age = 0; m_prio = (e_sel + 1) % N;
                end
            end
        end else if (e_rv != '0) begin
            m_granted = 1'b0; m_owner = -1;
        end else begin
            m_age++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        m_owner = -1; m_age = 0; m_prio = 0; m_granted = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) slv_req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                slv_add[i] = $urandom(); slv_wdata[i] = $urandom();
                slv_be[i] = BW'($urandom()); slv_we[i] = 1'($urandom());
            end
            mst_gnt = ($urandom_range(0, 2) != 0);
            mst_r_valid = ($urandom_range(0, 4) == 0);
            mst_r_opc = 1'($urandom()); mst_r_rdata = $urandom();
            #1;
            model_eval();
            checks++; if (mst_req !== e_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mst_req, e_req); end
            checks++; if (slv_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, slv_gnt, e_gnt); end
            checks++; if (slv_r_valid !== e_rv || slv_r_opc !== e_opc || timeout !== e_to) begin failures++; $display("FAIL rnd_resp cyc=%0d got=%b/%b/%b exp=%b/%b/%b", cyc, slv_r_valid, slv_r_opc, timeout, e_rv, e_opc, e_to); end
            checks++; if (slv_r_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, slv_r_rdata, e_rdata); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
            if (e_req) begin
                checks++;
                if (mst_add !== slv_add[e_sel] || mst_wdata !== slv_wdata[e_sel] || mst_be !== slv_be[e_sel] || mst_we !== slv_we[e_sel]) begin
                    failures++; $display("FAIL rnd_fields cyc=%0d got add=%h exp add=%h sel=%0d", cyc, mst_add, slv_add[e_sel], e_sel);
                end
            end
            model_commit();
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
